gray_stream_gen: RTL and testbench

Test-pattern transmitter for the gray pixel-stream interface: vsync, valid (href), clken and 8-bit data. It produces frames of IMG_HDISP x IMG_VDISP pixels with programmable blanking and pixel rate. It drives gray_median_filter and the other 3x3 VIP blocks in simulation and on-board self-test, replacing camera or BMP input.

---
 rtl/gray_stream_gen.sv | 207 ++++++++++++++++++++
 tb/tb_gray_stream_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_stream_gen.sv
// Gray pixel-stream pattern transmitter: framed vsync/valid/clken/data with
// programmable blanking, pixel rate and four test patterns.
module gray_stream_gen #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_BLANK   = 160,
  parameter int V_LEAD    = 10,
  parameter int V_TRAIL   = 10,
  parameter int CLK_DIV   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic [1:0] pattern_sel,
  input  logic [7:0] seed,
  output logic       busy,
  output logic       frame_done,
  output logic       post_gray_vsync,
  output logic       post_gray_valid,
  output logic       post_gray_clken,
  output logic [7:0] post_gray_data
);

  // state  | meaning
  // IDLE   | waiting for start
  // LEAD   | vsync high, before first line
  // ACTIVE | vsync and valid high, one pixel per tick
  // HBLANK | vsync high, valid low, after each line
  // TRAIL  | vsync low, after last line; frame_done on final tick

  localparam int XW   = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int YW   = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CMAX = (H_BLANK > V_LEAD) ?
                        ((H_BLANK > V_TRAIL) ? H_BLANK : V_TRAIL) :
                        ((V_LEAD > V_TRAIL) ? V_LEAD : V_TRAIL);
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [XW-1:0] X_LAST     = XW'(IMG_HDISP - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMG_VDISP - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LEAD_LAST  = CW'(V_LEAD - 1);
  localparam logic [CW-1:0] HB_LAST    = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] TRAIL_LAST = CW'(V_TRAIL - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_ACTIVE, S_HBLANK, S_TRAIL} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [7:0]      lfsr;
  logic [1:0]      pat;
  logic [DW-1:0]   div;

  logic            accept, emit;
  logic [7:0]      seed_fix;
  state_t          cur_state, nxt_state;
  logic [CW-1:0]   cur_cnt, nxt_cnt;
  logic [XW-1:0]   cur_x, nxt_x;
  logic [YW-1:0]   cur_y, nxt_y;
  logic [7:0]      cur_lfsr, nxt_lfsr;
  logic [1:0]      cur_pat, nxt_pat;
  logic [7:0]      x8, y8, pix;
  logic            fb;
  logic            o_vsync, o_valid, o_done;
  logic [7:0]      o_data;

  // Registers hold the position of the next tick to emit; on accept the
  // first LEAD tick is emitted directly from the freshly latched inputs.
  always_comb begin
    seed_fix = (seed == 8'h00) ? 8'h01 : seed;
    accept   = (state == S_IDLE) && !busy && start;
    emit     = accept || (busy && (state != S_IDLE) && (div == DIV_LAST));
    if (accept) begin
      cur_state = S_LEAD;
      cur_cnt   = '0;
      cur_x     = '0;
      cur_y     = '0;
      cur_lfsr  = seed_fix;
      cur_pat   = pattern_sel;
    end else begin
      cur_state = state;
      cur_cnt   = cnt;
      cur_x     = x;
      cur_y     = y;
      cur_lfsr  = lfsr;
      cur_pat   = pat;
    end
  end

  always_comb begin
    x8 = 8'(cur_x);
    y8 = 8'(cur_y);
    fb = cur_lfsr[7] ^ cur_lfsr[5] ^ cur_lfsr[4] ^ cur_lfsr[3];
    case (cur_pat)
      2'd0:    pix = x8;
      2'd1:    pix = y8;
      2'd2:    pix = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
      default: pix = cur_lfsr;
    endcase
  end

  always_comb begin
    nxt_state = cur_state;
    nxt_cnt   = cur_cnt + 1'b1;
    nxt_x     = cur_x;
    nxt_y     = cur_y;
    nxt_lfsr  = cur_lfsr;
    nxt_pat   = cur_pat;
    o_vsync   = 1'b0;
    o_valid   = 1'b0;
    o_done    = 1'b0;
    o_data    = 8'h00;
    case (cur_state)
      S_LEAD: begin
        o_vsync = 1'b1;
        if (cur_cnt == LEAD_LAST) begin
          nxt_state = S_ACTIVE;
          nxt_cnt   = '0;
        end
      end
      S_ACTIVE: begin
        o_vsync  = 1'b1;
        o_valid  = 1'b1;
        o_data   = pix;
        nxt_lfsr = {cur_lfsr[6:0], fb};
        nxt_cnt  = '0;
        if (cur_x == X_LAST) begin
          nxt_x     = '0;
          nxt_state = S_HBLANK;
        end else begin
          nxt_x = cur_x + 1'b1;
        end
      end
      S_HBLANK: begin
        o_vsync = 1'b1;
        if (cur_cnt == HB_LAST) begin
          nxt_cnt = '0;
          if (cur_y == Y_LAST) begin
            nxt_y     = '0;
            nxt_state = S_TRAIL;
          end else begin
            nxt_y     = cur_y + 1'b1;
            nxt_state = S_ACTIVE;
          end
        end
      end
      S_TRAIL: begin
        if (cur_cnt == TRAIL_LAST) begin
          o_done  = 1'b1;
          nxt_cnt = '0;
          if (continuous) begin
            nxt_state = S_LEAD;
            nxt_pat   = pattern_sel;
            nxt_lfsr  = seed_fix;
          end else begin
            nxt_state = S_IDLE;
          end
        end
      end
      default: nxt_cnt = cur_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      x               <= '0;
      y               <= '0;
      lfsr            <= 8'h00;
      pat             <= 2'd0;
      div             <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      post_gray_vsync <= 1'b0;
      post_gray_valid <= 1'b0;
      post_gray_clken <= 1'b0;
      post_gray_data  <= 8'h00;
    end else begin
      post_gray_clken <= emit;
      frame_done      <= 1'b0;
      if (accept) begin
        div  <= '0;
        busy <= 1'b1;
      end else begin
        if (busy) div <= (div == DIV_LAST) ? '0 : div + 1'b1;
        if (state == S_IDLE) busy <= 1'b0;
      end
      if (emit) begin
        state           <= nxt_state;
        cnt             <= nxt_cnt;
        x               <= nxt_x;
        y               <= nxt_y;
        lfsr            <= nxt_lfsr;
        pat             <= nxt_pat;
        post_gray_vsync <= o_vsync;
        post_gray_valid <= o_valid;
        post_gray_data  <= o_data;
        frame_done      <= o_done;
      end
    end
  end

endmodule

// File: tb/tb_gray_stream_gen.sv
// Bench for gray_stream_gen: three geometries/rates checked tick by tick
// against a frame model built from the pattern rules.
module tb_gray_stream_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic       continuous;
  logic [1:0] pattern_sel;
  logic [7:0] seed;

  logic       a_busy, a_done, a_vsync, a_valid, a_clken;
  logic [7:0] a_data;
  logic       b_busy, b_done, b_vsync, b_valid, b_clken;
  logic [7:0] b_data;
  logic       c_busy, c_done, c_vsync, c_valid, c_clken;
  logic [7:0] c_data;

  int          sel;
  logic [12:0] obs;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [12:0] exp_q[$];

  int hd_t[3] = '{4, 4, 20};
  int vd_t[3] = '{3, 3, 18};
  int hb_t[3] = '{2, 2, 1};
  int vl_t[3] = '{3, 3, 1};
  int vt_t[3] = '{2, 2, 1};
  int dv_t[3] = '{1, 3, 2};

  gray_stream_gen #(.IMG_HDISP(4), .IMG_VDISP(3), .H_BLANK(2), .V_LEAD(3), .V_TRAIL(2),
                    .CLK_DIV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .continuous(continuous),
    .pattern_sel(pattern_sel), .seed(seed), .busy(a_busy), .frame_done(a_done),
    .post_gray_vsync(a_vsync), .post_gray_valid(a_valid), .post_gray_clken(a_clken),
    .post_gray_data(a_data));

  gray_stream_gen #(.IMG_HDISP(4), .IMG_VDISP(3), .H_BLANK(2), .V_LEAD(3), .V_TRAIL(2),
                    .CLK_DIV(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .continuous(continuous),
    .pattern_sel(pattern_sel), .seed(seed), .busy(b_busy), .frame_done(b_done),
    .post_gray_vsync(b_vsync), .post_gray_valid(b_valid), .post_gray_clken(b_clken),
    .post_gray_data(b_data));

  gray_stream_gen #(.IMG_HDISP(20), .IMG_VDISP(18), .H_BLANK(1), .V_LEAD(1), .V_TRAIL(1),
                    .CLK_DIV(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .continuous(continuous),
    .pattern_sel(pattern_sel), .seed(seed), .busy(c_busy), .frame_done(c_done),
    .post_gray_vsync(c_vsync), .post_gray_valid(c_valid), .post_gray_clken(c_clken),
    .post_gray_data(c_data));

  always #5 clk = ~clk;

  // Observed word: {clken, vsync, valid, frame_done, busy, data}
  always_comb begin
    case (sel)
      0:       obs = {a_clken, a_vsync, a_valid, a_done, a_busy, a_data};
      1:       obs = {b_clken, b_vsync, b_valid, b_done, b_busy, b_data};
      default: obs = {c_clken, c_vsync, c_valid, c_done, c_busy, c_data};
    endcase
  end

  function automatic int lfsr_step(input int v);
    int ones;
    ones = 0;
    for (int b = 0; b < 8; b++)
      if ((((v & 184) >> b) & 1) != 0) ones++;
    return ((v * 2) % 256) + (ones % 2);
  endfunction

  function automatic logic [12:0] mk(input bit vs, input bit va, input bit dn, input int d);
    return {1'b1, vs, va, dn, 1'b1, d[7:0]};
  endfunction

  task automatic push_frame(input int s, input int pat, input int sd);
    int v;
    int pix;
    v = (sd == 0) ? 1 : sd;
    for (int i = 0; i < vl_t[s]; i++) exp_q.push_back(mk(1, 0, 0, 0));
    for (int y = 0; y < vd_t[s]; y++) begin
      for (int x = 0; x < hd_t[s]; x++) begin
        case (pat)
          0:       pix = x % 256;
          1:       pix = y % 256;
          2:       pix = (((x / 8) + (y / 8)) % 2 == 1) ? 255 : 0;
          default: pix = v;
        endcase
        exp_q.push_back(mk(1, 1, 0, pix));
        v = lfsr_step(v);
      end
      for (int h = 0; h < hb_t[s]; h++) exp_q.push_back(mk(1, 0, 0, 0));
    end
    for (int i = 0; i < vt_t[s]; i++) exp_q.push_back(mk(0, 0, i == vt_t[s] - 1, 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic [12:0] got,
                       input logic [12:0] expv);
    n_checks++;
    assert (got === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s[%0d]: got %h expected %h", tag, idx, got, expv);
    end
  endtask

  // Starts instance s and checks every cycle against exp_q; optional mid-run
  // input changes, abort by reset, or random scrambling of frozen inputs.
  task automatic run_stream(input int s, input int chg_idx, input int chg_pat,
                            input int chg_seed, input int cont_off_idx, input int rst_idx,
                            input bit scramble);
    int n;
    int cyc;
    logic [12:0] e;
    n   = exp_q.size();
    sel = s;
    start_v[s] = 1'b1;
    tick();
    start_v[s] = 1'b0;
    for (int i = 0; i < n; i++) begin
      e   = exp_q[i];
      cyc = (i == n - 1) ? 1 : dv_t[s];
      for (int c = 0; c < cyc; c++) begin
        if (c == 0) check("tick", i, obs, e);
        else check("hold", i, obs, {1'b0, e[11:10], 1'b0, 1'b1, e[7:0]});
        if (c == 0) begin
          if (i == chg_idx) begin
            pattern_sel = 2'(chg_pat);
            seed        = 8'(chg_seed);
          end
          if (i == cont_off_idx) continuous = 1'b0;
          if (scramble && i < n - 3) begin
            start_v[s]  = 1'($urandom_range(0, 1));
            continuous  = 1'($urandom_range(0, 1));
            pattern_sel = 2'($urandom_range(0, 3));
            seed        = 8'($urandom_range(0, 255));
          end else if (scramble && i == n - 3) begin
            start_v[s] = 1'b0;
            continuous = 1'b0;
          end
          if (i == rst_idx) begin
            rst_n = 1'b0;
            #1;
            check("reset_now", i, obs, 13'h0);
            for (int k = 0; k < 3; k++) begin
              tick();
              check("in_reset", k, obs, 13'h0);
            end
            rst_n = 1'b1;
            tick();
            check("after_reset", i, obs, 13'h0);
            return;
          end
        end
        tick();
      end
    end
    check("idle", n, obs, 13'h0);
    tick();
    check("idle2", n + 1, obs, 13'h0);
  endtask

  initial begin
    int s, p1, p2, sd1, sd2, n1;
    rst_n       = 1'b0;
    start_v     = 3'b000;
    continuous  = 1'b0;
    pattern_sel = 2'd0;
    seed        = 8'h00;
    sel         = 0;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      check("reset_state", k, obs, 13'h0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sel   = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_no_start", k, obs, 13'h0);
    end

    // H ramp, full rate and divided rate
    exp_q.delete(); push_frame(0, 0, 0); run_stream(0, -1, 0, 0, -1, -1, 0);
    exp_q.delete(); push_frame(1, 0, 0); run_stream(1, -1, 0, 0, -1, -1, 0);

    // LFSR with zero seed and a nonzero seed
    pattern_sel = 2'd3; seed = 8'h00;
    exp_q.delete(); push_frame(0, 3, 0); run_stream(0, -1, 0, 0, -1, -1, 0);
    seed = 8'hB8;
    exp_q.delete(); push_frame(0, 3, 184); run_stream(0, -1, 0, 0, -1, -1, 0);

    // Continuous: checker frame then V ramp, pattern changed mid-frame
    pattern_sel = 2'd2; seed = 8'h00; continuous = 1'b1;
    exp_q.delete(); push_frame(0, 2, 0); n1 = exp_q.size(); push_frame(0, 1, 0);
    run_stream(0, 10, 1, 0, n1 + 5, -1, 0);

    // Reset during the second active line, then a clean frame
    pattern_sel = 2'd0; seed = 8'h00; continuous = 1'b0;
    exp_q.delete(); push_frame(0, 0, 0); run_stream(0, -1, 0, 0, -1, 10, 0);
    exp_q.delete(); push_frame(0, 0, 0); run_stream(0, -1, 0, 0, -1, -1, 0);

    // Larger geometry with minimum blanking: checker, then random chain
    pattern_sel = 2'd2;
    exp_q.delete(); push_frame(2, 2, 0); run_stream(2, -1, 0, 0, -1, -1, 0);
    p1 = $urandom_range(0, 3); p2 = $urandom_range(0, 3);
    sd1 = $urandom_range(0, 255); sd2 = $urandom_range(0, 255);
    pattern_sel = 2'(p1); seed = 8'(sd1); continuous = 1'b1;
    exp_q.delete(); push_frame(2, p1, sd1); n1 = exp_q.size(); push_frame(2, p2, sd2);
    run_stream(2, 5, p2, sd2, n1 + 3, -1, 0);

    // Random frames with frozen inputs scrambled mid-frame
    for (int r = 0; r < 6; r++) begin
      s   = $urandom_range(0, 2);
      p1  = $urandom_range(0, 3);
      sd1 = $urandom_range(0, 255);
      pattern_sel = 2'(p1); seed = 8'(sd1); continuous = 1'b0;
      exp_q.delete(); push_frame(s, p1, sd1);
      run_stream(s, -1, 0, 0, -1, -1, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
